// File: rtl/conv_frame_sequencer_if.sv
// Handshake and status bundle between the frame sequencer and its neighbours.
// The master side drives the requests and beat valids; the slave side is the sequencer.
// The abort pair exists only when CONV_FRAME_SEQ_ABORT_EN is defined.
interface conv_frame_sequencer_if #(
  parameter int WA_BW  = 5,
  parameter int CNT_BW = 10
);
  logic              i_start;
  logic              i_w_valid;
  logic              o_w_ready;
  logic              o_w_en;
  logic [WA_BW-1:0]  o_w_addr;
  logic              i_px_valid;
  logic              o_px_ready;
  logic              o_px_en;
  logic              o_win_valid;
  logic [CNT_BW-1:0] o_out_cnt;
  logic              o_busy;
  logic              o_done;
`ifdef CONV_FRAME_SEQ_ABORT_EN
  logic              i_abort;
  logic              o_aborted;

  modport master (
    output i_start, i_w_valid, i_px_valid, i_abort,
    input  o_w_ready, o_w_en, o_w_addr, o_px_ready, o_px_en,
           o_win_valid, o_out_cnt, o_busy, o_done, o_aborted
  );

  modport slave (
    input  i_start, i_w_valid, i_px_valid, i_abort,
    output o_w_ready, o_w_en, o_w_addr, o_px_ready, o_px_en,
           o_win_valid, o_out_cnt, o_busy, o_done, o_aborted
  );
`else
  modport master (
    output i_start, i_w_valid, i_px_valid,
    input  o_w_ready, o_w_en, o_w_addr, o_px_ready, o_px_en,
           o_win_valid, o_out_cnt, o_busy, o_done
  );

  modport slave (
    input  i_start, i_w_valid, i_px_valid,
    output o_w_ready, o_w_en, o_w_addr, o_px_ready, o_px_en,
           o_win_valid, o_out_cnt, o_busy, o_done
  );
`endif
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame-level scheduler for the streaming 2-D convolution core.
// Sequence per frame: load KERNEL_SIZE^2 weights, feed DATA_SIZE^2 pixels in raster
// order while flagging window-completing pixels, flush the core for DRAIN_CYCLES, then
// pulse o_done for one cycle.
// Optional feature: define CONV_FRAME_SEQ_ABORT_EN to add i_abort / o_aborted.
module conv_frame_sequencer #(
  parameter int DATA_SIZE    = 32,
  parameter int KERNEL_SIZE  = 5,
  parameter int STRIDE       = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_frame_sequencer_if.slave bus
);

  localparam int OUT_DIM = (DATA_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int KK      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int WA_BW   = (KK > 1) ? $clog2(KK) : 1;
  localparam int CNT_BW  = $clog2(OUT_DIM * OUT_DIM + 1);
  localparam int POS_BW  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int DR_BW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam int unsigned KM1 = KERNEL_SIZE - 1;
  localparam int unsigned STR = STRIDE;

  localparam logic [WA_BW-1:0]  W_LAST   = WA_BW'(KK - 1);
  localparam logic [POS_BW-1:0] POS_LAST = POS_BW'(DATA_SIZE - 1);
  localparam logic [DR_BW-1:0]  DR_LAST  = DR_BW'(DRAIN_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_FEED   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [WA_BW-1:0]  w_idx;
  logic [POS_BW-1:0] row;
  logic [POS_BW-1:0] col;
  logic [DR_BW-1:0]  drain_cnt;
  logic [CNT_BW-1:0] out_cnt;
  logic              win_vld_p1;
  logic              w_en;
  logic              px_en;
  logic              abort;

  // Pixel (r,c) closes a window when it is the bottom-right corner of a stride-aligned
  // KxK footprint; unsigned throughout, modulo only evaluated when STRIDE > 1.
  function automatic logic win_hit(input logic [POS_BW-1:0] r, input logic [POS_BW-1:0] c);
    int unsigned ru;
    int unsigned cu;
    logic        hit;
    ru  = 32'(r);
    cu  = 32'(c);
    hit = (ru >= KM1) && (cu >= KM1);
    if (STR > 32'd1)
      hit = hit && (((ru - KM1) % STR) == 32'd0) && (((cu - KM1) % STR) == 32'd0);
    return hit;
  endfunction

  assign bus.o_w_ready   = (state == S_LOAD_W);
  assign bus.o_px_ready  = (state == S_FEED);
  assign w_en            = bus.i_w_valid & bus.o_w_ready;
  assign px_en           = bus.i_px_valid & bus.o_px_ready;
  assign bus.o_w_en      = w_en;
  assign bus.o_px_en     = px_en;
  assign bus.o_w_addr    = w_idx;
  assign bus.o_win_valid = win_vld_p1;
  assign bus.o_out_cnt   = out_cnt;
  assign bus.o_busy      = (state != S_IDLE);
  assign bus.o_done      = (state == S_DONE);

`ifdef CONV_FRAME_SEQ_ABORT_EN
  logic aborted_q;

  assign abort         = bus.i_abort && (state != S_IDLE);
  assign bus.o_aborted = aborted_q;

  // One-cycle acknowledgement that a running frame was abandoned.
  always_ff @(posedge clk) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= abort;
  end
`else
  assign abort = 1'b0;
`endif

  // Frame FSM with weight index, raster position, drain timer and window counter.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state      <= S_IDLE;
      w_idx      <= '0;
      row        <= '0;
      col        <= '0;
      drain_cnt  <= '0;
      out_cnt    <= '0;
      win_vld_p1 <= 1'b0;
    end else begin
      win_vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            state   <= S_LOAD_W;
            w_idx   <= '0;
            row     <= '0;
            col     <= '0;
            out_cnt <= '0;
          end
        end
        S_LOAD_W: begin
          if (w_en) begin
            if (w_idx == W_LAST) state <= S_FEED;
            else                 w_idx <= w_idx + WA_BW'(1);
          end
        end
        S_FEED: begin
          // p0 -> p1: window flag for the accepted pixel appears on the next cycle
          if (px_en) begin
            if (win_hit(row, col)) begin
              win_vld_p1 <= 1'b1;
              out_cnt    <= out_cnt + CNT_BW'(1);
            end
            if (col == POS_LAST) begin
              col <= '0;
              if (row == POS_LAST) begin
                state     <= S_DRAIN;
                drain_cnt <= '0;
              end else begin
                row <= row + POS_BW'(1);
              end
            end else begin
              col <= col + POS_BW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DR_LAST) state     <= S_DONE;
          else                      drain_cnt <= drain_cnt + DR_BW'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer: two instances (STRIDE 1 and STRIDE 2)
// share one randomized stimulus stream; expected weight addresses, window pixel
// indices and per-frame window totals are queued at frame start and consumed by a
// negedge monitor.
`timescale 1ns/1ps
module tb_conv_frame_sequencer;

  localparam int D       = 32;
  localparam int K       = 5;
  localparam int DR      = 4;
  localparam int KK      = K * K;
  localparam int WA_BW   = $clog2(KK);
  localparam int OD0     = (D - K) / 1 + 1;
  localparam int OD1     = (D - K) / 2 + 1;
  localparam int CB0     = $clog2(OD0 * OD0 + 1);
  localparam int CB1     = $clog2(OD1 * OD1 + 1);
  localparam int TIMEOUT = 8000;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic start    = 1'b0;
  logic w_valid  = 1'b0;
  logic px_valid = 1'b0;
  logic rst_q    = 1'b1;

  always #5 clk = ~clk;

  conv_frame_sequencer_if #(.WA_BW(WA_BW), .CNT_BW(CB0)) bus0 ();
  conv_frame_sequencer_if #(.WA_BW(WA_BW), .CNT_BW(CB1)) bus1 ();

  assign bus0.i_start    = start;
  assign bus0.i_w_valid  = w_valid;
  assign bus0.i_px_valid = px_valid;
  assign bus1.i_start    = start;
  assign bus1.i_w_valid  = w_valid;
  assign bus1.i_px_valid = px_valid;

  conv_frame_sequencer #(.DATA_SIZE(D), .KERNEL_SIZE(K), .STRIDE(1), .DRAIN_CYCLES(DR)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  conv_frame_sequencer #(.DATA_SIZE(D), .KERNEL_SIZE(K), .STRIDE(2), .DRAIN_CYCLES(DR)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  logic        w_rdy [2];
  logic        px_rdy[2];
  logic        w_en  [2];
  logic        px_en [2];
  logic        win   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] waddr [2];
  logic [31:0] cnt   [2];

  assign w_rdy[0]  = bus0.o_w_ready;   assign w_rdy[1]  = bus1.o_w_ready;
  assign px_rdy[0] = bus0.o_px_ready;  assign px_rdy[1] = bus1.o_px_ready;
  assign w_en[0]   = bus0.o_w_en;      assign w_en[1]   = bus1.o_w_en;
  assign px_en[0]  = bus0.o_px_en;     assign px_en[1]  = bus1.o_px_en;
  assign win[0]    = bus0.o_win_valid; assign win[1]    = bus1.o_win_valid;
  assign busy[0]   = bus0.o_busy;      assign busy[1]   = bus1.o_busy;
  assign done[0]   = bus0.o_done;      assign done[1]   = bus1.o_done;
  assign waddr[0]  = 32'(bus0.o_w_addr);
  assign waddr[1]  = 32'(bus1.o_w_addr);
  assign cnt[0]    = 32'(bus0.o_out_cnt);
  assign cnt[1]    = 32'(bus1.o_out_cnt);

`ifdef CONV_FRAME_SEQ_ABORT_EN
  logic abort = 1'b0;
  logic abt[2];
  logic abort_prev[2];
  assign bus0.i_abort = abort;
  assign bus1.i_abort = abort;
  assign abt[0] = bus0.o_aborted;
  assign abt[1] = bus1.o_aborted;
`endif

  // Scoreboard queues (pushed by stimulus, popped by monitor)
  int w_q   [2][$];
  int win_q [2][$];
  int done_q[2][$];

  // Monitor-owned state
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int to_ack = 0;
  int to_req = 0;
  int px_cnt     [2] = '{0, 0};
  int prev_idx   [2] = '{0, 0};
  int last_px_cyc[2] = '{0, 0};
  int pd         [2] = '{0, 0};
  int held       [2] = '{0, 0};
  bit prev_en    [2] = '{1'b0, 1'b0};
  bit start_s    [2] = '{1'b0, 1'b0};

  task automatic check(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d got=%0d exp=%0d (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  // Reset as seen by the DUT on the last active edge
  always @(posedge clk) rst_q <= rst_n;

  // Monitor: compare DUT outputs against the queued expectations away from the active edge
  always @(negedge clk) begin
    bit exp_win;
    int e;
    cyc++;
    if (to_req != to_ack) begin
      to_ack = to_req;
      check("frame_timeout", 0, 1, 0);
    end
    for (int d = 0; d < 2; d++) begin
      if (!rst_q) begin
        check("reset_flags", d, {busy[d], done[d], win[d], w_rdy[d], px_rdy[d]}, 0);
        check("reset_out_cnt", d, int'(cnt[d]), 0);
        px_cnt[d]  = 0;
        prev_en[d] = 1'b0;
        pd[d]      = 0;
`ifdef CONV_FRAME_SEQ_ABORT_EN
        abort_prev[d] = 1'b0;
`endif
        continue;
      end

      check("w_en", d, int'(w_en[d]), int'(w_valid & w_rdy[d]));
      check("px_en", d, int'(px_en[d]), int'(px_valid & px_rdy[d]));
      check("ready_excl", d, int'(w_rdy[d] & px_rdy[d]), 0);

`ifdef CONV_FRAME_SEQ_ABORT_EN
      if (abort_prev[d]) begin
        check("aborted_pulse", d, int'(abt[d]), 1);
        check("abort_idle", d, {busy[d], done[d], win[d]}, 0);
        check("abort_cnt", d, int'(cnt[d]), 0);
        px_cnt[d]  = 0;
        prev_en[d] = 1'b0;
        pd[d]      = 0;
      end else begin
        check("aborted_quiet", d, int'(abt[d]), 0);
      end
      abort_prev[d] = abort && busy[d];
`endif

      if (w_en[d]) begin
        check("w_expected", d, int'(w_q[d].size() > 0), 1);
        if (w_q[d].size() > 0) begin
          e = w_q[d].pop_front();
          check("w_addr", d, int'(waddr[d]), e);
        end
      end

      exp_win = prev_en[d] && (win_q[d].size() > 0) && (win_q[d][0] == prev_idx[d]);
      check("win_valid", d, int'(win[d]), int'(exp_win));
      if (exp_win) void'(win_q[d].pop_front());
      prev_en[d] = 1'b0;

      if (px_en[d]) begin
        check("px_after_weights", d, int'(w_q[d].size()), 0);
        check("px_in_frame", d, int'(px_cnt[d] < D * D), 1);
        prev_en[d]  = 1'b1;
        prev_idx[d] = px_cnt[d];
        px_cnt[d]++;
        if (px_cnt[d] == D * D) last_px_cyc[d] = cyc;
      end

      if (pd[d] == 1) begin
        check("idle_after_done", d, int'(busy[d]), 0);
        check("cnt_hold", d, int'(cnt[d]), held[d]);
        start_s[d] = start;
        pd[d] = 2;
      end else if (pd[d] == 2) begin
        if (start_s[d]) begin
          check("load_after_done", d, {busy[d], w_rdy[d]}, 3);
          check("cnt_cleared", d, int'(cnt[d]), 0);
        end else begin
          check("idle_hold", d, int'(busy[d]), 0);
        end
        pd[d] = 0;
      end

      if (done[d]) begin
        check("done_expected", d, int'(done_q[d].size() > 0), 1);
        if (done_q[d].size() > 0) begin
          e = done_q[d].pop_front();
          check("out_cnt_done", d, int'(cnt[d]), e);
          check("windows_left", d, int'(win_q[d].size()), 0);
          check("done_latency", d, cyc - last_px_cyc[d], DR + 1);
          check("px_total", d, px_cnt[d], D * D);
          check("busy_in_done", d, int'(busy[d]), 1);
        end
        held[d]   = int'(cnt[d]);
        px_cnt[d] = 0;
        pd[d]     = 1;
      end
    end
  end

  // Raise i_start (DUT known idle) and queue every expectation for the new frame
  task automatic start_frame();
    int s;
    int od;
    start = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s  = (d == 0) ? 1 : 2;
      od = (d == 0) ? OD0 : OD1;
      for (int i = 0; i < KK; i++) w_q[d].push_back(i);
      for (int oy = 0; oy < od; oy++)
        for (int ox = 0; ox < od; ox++)
          win_q[d].push_back((K - 1 + oy * s) * D + (K - 1 + ox * s));
      done_q[d].push_back(od * od);
    end
  endtask

  task automatic flush();
    for (int d = 0; d < 2; d++) begin
      w_q[d].delete();
      win_q[d].delete();
      done_q[d].delete();
    end
  endtask

  // Drive random beats until o_done (or stop_px pixels accepted); leaves i_start = chain
  task automatic run_frame(input int mode, input int stop_px, input bit chain);
    bit ended;
    ended = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < TIMEOUT; n++) begin
      if (bus0.o_done) begin ended = 1'b1; break; end
      if (stop_px > 0 && px_cnt[0] >= stop_px) begin ended = 1'b1; break; end
      start    = ($urandom_range(0, 7) == 0);
      w_valid  = (mode == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) != 0);
      px_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    if (!ended) to_req++;
    w_valid  = 1'b0;
    px_valid = 1'b0;
    start    = chain;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame A: pixels held valid through weight load, random weight gaps, stray starts,
    // start held through DONE into the following idle cycle
    start_frame();
    run_frame(0, 0, 1'b1);
    @(posedge clk); #1;
    start_frame();

    // Frame B: chained start, reset at pixel 500
    run_frame(1, 500, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    #1;

    // Frame C: full random frame after reset
    start_frame();
    run_frame(1, 0, 1'b0);
    @(posedge clk); #1;

`ifdef CONV_FRAME_SEQ_ABORT_EN
    // Frame D: abort while draining
    start_frame();
    run_frame(1, D * D, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1;
    start_frame();
    run_frame(1, 0, 1'b0);
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
